// File: rtl/alu_ops_pkg.sv
// ---------------------------------------------------------------------------
// alu_ops_pkg
// Shared definitions for the sequential ALU and the ALU control decoder.
//   alu_op_e     : 4-bit operation codes produced by the ALU control decoder
//   alu_state_e  : control FSM state encoding of seq_alu_unit
//   is_iterative : true for operations that run on the multi-cycle datapath
// ---------------------------------------------------------------------------
package alu_ops_pkg;

    typedef enum logic [3:0] {
        OP_AND   = 4'b0000,
        OP_OR    = 4'b0001,
        OP_NOR   = 4'b0010,
        OP_ADD   = 4'b0011,
        OP_SUB   = 4'b0100,
        OP_SLT   = 4'b0101,
        OP_SLL   = 4'b0110,
        OP_SRL   = 4'b0111,
        OP_LUI   = 4'b1000,
        OP_NOP   = 4'b1001,
        OP_MULTU = 4'b1010,
        OP_DIVU  = 4'b1011,
        OP_MFHI  = 4'b1100,
        OP_MFLO  = 4'b1101
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } alu_state_e;

    // MULTU and DIVU are the only operations that need the iterative datapath.
    function automatic logic is_iterative(input logic [3:0] op);
        return (op == OP_MULTU) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_iter.sv
// ---------------------------------------------------------------------------
// mult_div_iter
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per
// clock, WIDTH iterations per operation. HI/LO are committed on the last
// iteration only, so an operation aborted by reset leaves them untouched
// (reset clears them anyway).
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   start_i         : load operands and begin (op_i selects MULTU or DIVU)
//   op_i            : operation code, OP_DIVU selects division
//   a_i, b_i        : operands (rs, rt)
//   last_o          : high during the final iteration cycle
//   lo_next_o       : LO value being committed in the final iteration
//   hi_o, lo_o      : committed HI / LO registers
// ---------------------------------------------------------------------------
module mult_div_iter
    import alu_ops_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             last_o,
    output logic [WIDTH-1:0] lo_next_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH);

    logic               running;
    logic [CW-1:0]      count;
    logic               is_div;
    logic               start_div;
    logic [WIDTH-1:0]   operand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;

    assign start_div = (op_i == OP_DIVU);

    // One iteration step. acc holds {upper, lower}:
    //   multiply: {partial product, remaining multiplier bits}, operand = multiplicand
    //   divide  : {partial remainder, remaining dividend/quotient bits}, operand = divisor
    // A zero divisor always "fits", giving an all-ones quotient and leaving
    // the dividend as remainder, which is exactly the required behaviour.
    always_comb begin
        acc_next  = '0;
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift[WIDTH-1:0] - operand;
        if (is_div) begin
            if (div_shift >= {1'b0, operand})
                acc_next = {div_diff, acc[WIDTH-2:0], 1'b1};
            else
                acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    assign last_o    = running && (count == CW'(WIDTH - 1));
    assign lo_next_o = acc_next[WIDTH-1:0];

    // Operand load on start, then WIDTH iterations; HI/LO commit on the last.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            running <= 1'b0;
            count   <= '0;
            is_div  <= 1'b0;
            operand <= '0;
            acc     <= '0;
            hi_o    <= '0;
            lo_o    <= '0;
        end else if (start_i) begin
            running <= 1'b1;
            count   <= '0;
            is_div  <= start_div;
            operand <= start_div ? b_i : a_i;
            acc     <= {{WIDTH{1'b0}}, (start_div ? a_i : b_i)};
        end else if (running) begin
            acc   <= acc_next;
            count <= count + CW'(1);
            if (last_o) begin
                running <= 1'b0;
                hi_o    <= acc_next[2*WIDTH-1:WIDTH];
                lo_o    <= acc_next[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/seq_alu_unit.sv
// ---------------------------------------------------------------------------
// seq_alu_unit
// Sequential ALU: single-cycle logic/arith/shift ops plus iterative MULTU and
// DIVU with HI/LO registers. Handshake is start_i/ready_o in, done_o pulse out.
// Ports:
//   clk, reset       : clock, asynchronous active-low reset
//   start_i          : request strobe, accepted only while ready_o=1
//   alu_operation_i  : 4-bit op code (alu_ops_pkg::alu_op_e)
//   a_i, b_i         : operands A (rs) and B (rt / immediate)
//   shamt_i          : shift amount for SLL/SRL
//   ready_o          : idle, can accept a request
//   done_o           : one-cycle pulse, result_o valid
//   result_o         : registered result, held until next done_o
//   zero_o           : result_o == 0
// ---------------------------------------------------------------------------
module seq_alu_unit
    import alu_ops_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [3:0]       alu_operation_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [4:0]       shamt_i,
    output logic             ready_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o
);

    alu_state_e       state;
    logic             accept;
    logic             iter_op;
    logic [WIDTH-1:0] single_result;
    logic             md_last;
    logic [WIDTH-1:0] md_lo_next;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    assign accept  = start_i && ready_o;
    assign iter_op = is_iterative(alu_operation_i);

    mult_div_iter #(
        .WIDTH (WIDTH)
    ) u_mult_div (
        .clk       (clk),
        .reset     (reset),
        .start_i   (accept && iter_op),
        .op_i      (alu_operation_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .last_o    (md_last),
        .lo_next_o (md_lo_next),
        .hi_o      (hi),
        .lo_o      (lo)
    );

    // Single-cycle results; MFHI/MFLO read HI/LO as committed so far.
    always_comb begin
        single_result = '0;
        case (alu_operation_i)
            OP_AND:  single_result = a_i & b_i;
            OP_OR:   single_result = a_i | b_i;
            OP_NOR:  single_result = ~(a_i | b_i);
            OP_ADD:  single_result = a_i + b_i;
            OP_SUB:  single_result = a_i - b_i;
            OP_SLT:  single_result = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            OP_SLL:  single_result = b_i << shamt_i;
            OP_SRL:  single_result = b_i >> shamt_i;
            OP_LUI:  single_result = WIDTH'({b_i[15:0], 16'h0000});
            OP_MFHI: single_result = hi;
            OP_MFLO: single_result = lo;
            default: single_result = '0;
        endcase
    end

    // Control FSM with registered ready/done/result. Requests arriving while
    // BUSY or DONE are dropped because ready_o is low in those states.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            ready_o  <= 1'b1;
            done_o   <= 1'b0;
            result_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        ready_o <= 1'b0;
                        if (iter_op) begin
                            state <= ST_BUSY;
                        end else begin
                            state    <= ST_DONE;
                            done_o   <= 1'b1;
                            result_o <= single_result;
                        end
                    end
                end
                ST_BUSY: begin
                    if (md_last) begin
                        state    <= ST_DONE;
                        done_o   <= 1'b1;
                        result_o <= md_lo_next;
                    end
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    ready_o <= 1'b1;
                    done_o  <= 1'b0;
                end
                default: begin
                    state   <= ST_IDLE;
                    ready_o <= 1'b1;
                    done_o  <= 1'b0;
                end
            endcase
        end
    end

    assign zero_o = (result_o == '0);

endmodule

// File: tb/tb_seq_alu_unit.sv
// ---------------------------------------------------------------------------
// tb_seq_alu_unit
// Self-checking bench for seq_alu_unit: directed scenarios followed by random
// requests, all compared against a plain-arithmetic reference model of the
// ALU and its HI/LO registers.
// ---------------------------------------------------------------------------
module tb_seq_alu_unit;

    localparam int WIDTH = 32;

    logic             clk;
    logic             reset;
    logic             start_i;
    logic [3:0]       alu_operation_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [4:0]       shamt_i;
    logic             ready_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    seq_alu_unit #(
        .WIDTH (WIDTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start_i         (start_i),
        .alu_operation_i (alu_operation_i),
        .a_i             (a_i),
        .b_i             (b_i),
        .shamt_i         (shamt_i),
        .ready_o         (ready_o),
        .done_o          (done_o),
        .result_o        (result_o),
        .zero_o          (zero_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counted, and reported on mismatch.
    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic st, input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic [4:0] sh);
        start_i         = st;
        alu_operation_i = op;
        a_i             = a;
        b_i             = b;
        shamt_i         = sh;
    endtask

    // Issue one request from a negedge, check latency, result, zero flag and
    // return to idle; then commit the model's HI/LO. Ends on a negedge.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh, input string tag);
        logic [31:0] exp_res;
        logic [31:0] new_hi;
        logic [31:0] new_lo;
        logic [63:0] prod;
        int          exp_lat;
        int          lat;
        bit          iter;
        iter    = 1'b0;
        new_hi  = model_hi;
        new_lo  = model_lo;
        exp_res = '0;
        case (op)
            4'h0: exp_res = a & b;
            4'h1: exp_res = a | b;
            4'h2: exp_res = ~(a | b);
            4'h3: exp_res = a + b;
            4'h4: exp_res = a - b;
            4'h5: exp_res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h6: exp_res = b << sh;
            4'h7: exp_res = b >> sh;
            4'h8: exp_res = b * 32'h0001_0000;
            4'hA: begin
                prod    = 64'(a) * 64'(b);
                new_hi  = prod[63:32];
                new_lo  = prod[31:0];
                exp_res = new_lo;
                iter    = 1'b1;
            end
            4'hB: begin
                if (b == 0) begin
                    new_hi = a;
                    new_lo = 32'hFFFF_FFFF;
                end else begin
                    new_hi = a % b;
                    new_lo = a / b;
                end
                exp_res = new_lo;
                iter    = 1'b1;
            end
            4'hC: exp_res = model_hi;
            4'hD: exp_res = model_lo;
            default: exp_res = '0;
        endcase
        exp_lat = iter ? WIDTH + 1 : 1;

        apply_stimulus(1'b1, op, a, b, sh);
        @(posedge clk);
        #1;
        apply_stimulus(1'b0, 4'($urandom), $urandom, $urandom, 5'($urandom));
        lat = 0;
        for (int k = 1; k <= WIDTH + 8 && lat == 0; k++) begin
            @(negedge clk);
            if (done_o) lat = k;
        end
        check_output({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        check_output({tag, "/result"}, result_o, exp_res);
        check_output({tag, "/zero"}, 32'(zero_o), (exp_res == 0) ? 32'd1 : 32'd0);
        @(negedge clk);
        check_output({tag, "/done_pulse"}, 32'(done_o), 32'd0);
        check_output({tag, "/ready_back"}, 32'(ready_o), 32'd1);
        check_output({tag, "/result_held"}, result_o, exp_res);
        model_hi = new_hi;
        model_lo = new_lo;
    endtask

    initial begin
        int          done_cnt;
        int          lat;
        logic [31:0] seen_res;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [3:0]  rop;

        reset = 1'b0;
        apply_stimulus(1'b0, 4'h0, '0, '0, '0);

        // Reset state
        repeat (3) @(negedge clk);
        check_output("reset/ready", 32'(ready_o), 32'd1);
        check_output("reset/done", 32'(done_o), 32'd0);
        check_output("reset/result", result_o, 32'd0);
        check_output("reset/zero", 32'(zero_o), 32'd1);

        // Release reset; the very next edge must accept a request
        reset = 1'b1;
        run_op(4'h3, 32'h7FFF_FFFF, 32'h1, 5'd0, "add_ovf");
        run_op(4'h4, 32'h1234, 32'h1234, 5'd0, "sub_zero");

        // MULTU with carry into HI, then HI readback
        run_op(4'hA, 32'hFFFF_FFFF, 32'h2, 5'd0, "multu");
        run_op(4'hC, '0, '0, 5'd0, "mfhi_mul");
        run_op(4'hD, '0, '0, 5'd0, "mflo_mul");

        // Divide by zero
        run_op(4'hB, 32'd100, 32'd0, 5'd0, "divu_zero");
        run_op(4'hC, '0, '0, 5'd0, "mfhi_div0");

        // NOP codes and a few single-cycle boundary values
        run_op(4'h9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, "nop_1001");
        run_op(4'hF, 32'h1, 32'h1, 5'd1, "nop_1111");
        run_op(4'h5, 32'h8000_0000, 32'h1, 5'd0, "slt_neg");
        run_op(4'h6, 32'h0, 32'h8000_0001, 5'd31, "sll_31");
        run_op(4'h7, 32'h0, 32'h8000_0001, 5'd31, "srl_31");
        run_op(4'h8, 32'h0, 32'hABCD_1234, 5'd0, "lui");

        // Busy/ignore: an ADD pulsed during DIVU must be dropped
        apply_stimulus(1'b1, 4'hB, 32'd7, 32'd2, 5'd0);
        @(posedge clk);
        #1;
        start_i  = 1'b0;
        done_cnt = 0;
        lat      = 0;
        seen_res = '0;
        for (int k = 1; k <= WIDTH + 10; k++) begin
            @(negedge clk);
            if (done_o) begin
                done_cnt++;
                if (lat == 0) lat = k;
                seen_res = result_o;
            end
            if (k == 5) apply_stimulus(1'b1, 4'h3, 32'h10, 32'h20, 5'd0);
            if (k == 6) start_i = 1'b0;
        end
        check_output("busy/done_count", 32'(done_cnt), 32'd1);
        check_output("busy/latency", 32'(lat), 32'(WIDTH + 1));
        check_output("busy/result", seen_res, 32'd3);
        model_hi = 32'd1;
        model_lo = 32'd3;
        run_op(4'hC, '0, '0, 5'd0, "busy_mfhi");
        run_op(4'hD, '0, '0, 5'd0, "busy_mflo");

        // Reset mid-operation aborts without done or HI/LO update
        apply_stimulus(1'b1, 4'hA, 32'd3, 32'd5, 5'd0);
        @(posedge clk);
        #1;
        start_i  = 1'b0;
        done_cnt = 0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (done_o) done_cnt++;
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_output("midrst/ready", 32'(ready_o), 32'd1);
        check_output("midrst/done", 32'(done_o), 32'd0);
        check_output("midrst/result", result_o, 32'd0);
        repeat (2) @(negedge clk);
        reset    = 1'b1;
        model_hi = '0;
        model_lo = '0;
        for (int k = 1; k <= WIDTH + 5; k++) begin
            @(negedge clk);
            if (done_o) done_cnt++;
        end
        check_output("midrst/no_done", 32'(done_cnt), 32'd0);
        run_op(4'hD, '0, '0, 5'd0, "midrst_mflo");
        run_op(4'hC, '0, '0, 5'd0, "midrst_mfhi");

        // Random requests against the reference model
        for (int n = 0; n < 24; n++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            if (n % 6 == 0) rop = 4'hA;
            if (n % 6 == 3) rop = 4'hB;
            run_op(rop, ra, rb, 5'($urandom), $sformatf("rand%0d_op%h", n, rop));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_alu_unit.md
SEQ_ALU_UNIT -- requirements
Module: seq_alu_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of operands, result and HI/LO.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start_i  input  1  request strobe; accepted only when ready_o=1.
REQ-005 SHALL have port alu_operation_i  input  4  operation code, the same 4-bit encoding the ALU control decoder produces.
REQ-006 SHALL have port a_i  input  WIDTH  operand A (rs).
REQ-007 SHALL have port b_i  input  WIDTH  operand B (rt or immediate).
REQ-008 SHALL have port shamt_i  input  5  shift amount.
REQ-009 SHALL have port ready_o  output  1  unit idle, able to accept start_i.
REQ-010 SHALL have port done_o  output  1  one-cycle pulse, result_o valid.
REQ-011 SHALL have port result_o  output  WIDTH  registered result, held until next done_o.
REQ-012 SHALL have port zero_o  output  1  high when result_o == 0.

Function
REQ-013 SHALL decode: 0000 AND, 0001 OR, 0010 NOR, 0011 ADD, 0100 SUB, 0101 SLT (signed), 0110 SLL b by shamt, 0111 SRL b by shamt, 1000 LUI ({b[15:0],16'h0}), 1010 MULTU, 1011 DIVU, 1100 MFHI, 1101 MFLO; 1001 and all others are NOP (result 0).
REQ-014 SHALL sample alu_operation_i, a_i, b_i, shamt_i only on the cycle start_i=1 and ready_o=1; inputs on other cycles are ignored.
REQ-015 SHALL implement FSM states IDLE, BUSY, DONE: IDLE->DONE on accepted single-cycle op; IDLE->BUSY on accepted MULTU/DIVU; BUSY->DONE when iteration counter reaches WIDTH-1; DONE->IDLE unconditionally.
REQ-016 SHALL assert ready_o only in IDLE; start_i in BUSY or DONE is ignored, not queued.
REQ-017 SHALL assert done_o only in DONE, exactly one cycle per accepted request.
REQ-018 SHALL give single-cycle ops latency 1: start accepted at edge N, done_o high in cycle N+1.
REQ-019 SHALL give MULTU/DIVU latency WIDTH+1: done_o high in cycle N+WIDTH+1.
REQ-020 SHALL compute ADD/SUB modulo 2^WIDTH, no overflow trap or flag.
REQ-021 SHALL compute MULTU by iterative shift-add, one bit per cycle, full 2*WIDTH product: HI=upper, LO=lower; result_o=LO.
REQ-022 SHALL compute DIVU by restoring division, one bit per cycle: LO=quotient, HI=remainder; result_o=LO.
REQ-023 SHALL handle DIVU by zero without exception: LO=all ones, HI=a_i, same latency.
REQ-024 SHALL update HI/LO only at the BUSY->DONE transition; other ops leave HI/LO unchanged.
REQ-025 SHALL return HI (MFHI) or LO (MFLO) with latency 1; MFHI/MFLO returns HI/LO as committed before the current request.
REQ-026 SHALL derive zero_o combinationally from result_o.

Reset
REQ-027 SHALL, while reset=0, force state IDLE, ready_o=1, done_o=0, result_o=0, zero_o=1, HI=0, LO=0, iteration counter=0.
REQ-028 SHALL abort an in-flight MULTU/DIVU on reset with no done_o and no HI/LO update.
REQ-029 SHALL accept start_i on the first rising edge after reset deasserts.

Structure
REQ-030 SHALL place the 4-bit opcode constants and FSM state encoding in shared package alu_ops_pkg, reused by the ALU control decoder.
REQ-031 SHALL isolate the iterative multiply/divide datapath (counter, partial product/remainder, HI/LO) in sub-module mult_div_iter with start/done handshake to the parent FSM.
REQ-032 SHALL keep single-cycle ops in the parent as combinational logic feeding the result register.

Verification
REQ-033 SHALL cover ADD: op=0011, a=0x7FFFFFFF, b=1 -> next cycle done_o=1, result_o=0x80000000, zero_o=0.
REQ-034 SHALL cover SUB/zero: op=0100, a=b=0x1234 -> result_o=0, zero_o=1, latency 1.
REQ-035 SHALL cover MULTU: a=0xFFFFFFFF, b=2 -> done_o at cycle N+33, LO=result_o=0xFFFFFFFE, then MFHI -> 0x00000001.
REQ-036 SHALL cover DIVU by zero: a=100, b=0 -> done_o at N+33, result_o=0xFFFFFFFF; MFHI -> 100.
REQ-037 SHALL cover busy/ignore: start DIVU a=7,b=2, pulse start_i ADD in cycle N+5 -> ADD ignored, single done_o, LO=3, HI=1.
REQ-038 SHALL cover reset mid-op: start MULTU 3*5, reset=0 at N+10 -> no done_o, ready_o=1, MFLO afterwards -> 0.
